// File: rtl/pi_error_calc_mc.sv
// Multi-channel PI error stage: error = ref[ch] - sample, two-stage pipeline with signed saturation.
// Optional deadband before saturation when PI_ERR_DEADBAND_EN is defined.
module pi_error_calc_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ERR_WIDTH  = 16,
  parameter int NUM_CH     = 3,
  parameter int CH_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ref_wr_en,
  input  logic [CH_WIDTH-1:0]   ref_wr_ch,
  input  logic [DATA_WIDTH-1:0] ref_wr_data,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [CH_WIDTH-1:0]   s_tuser,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [ERR_WIDTH-1:0]  m_tdata,
  output logic [CH_WIDTH-1:0]   m_tuser,
  output logic                  m_tsat,
  output logic [15:0]           sat_count,
  output logic                  ch_err,
  input  logic                  stat_clr
`ifdef PI_ERR_DEADBAND_EN
  ,
  input  logic [DATA_WIDTH-1:0] deadband
`endif
);

  localparam logic [CH_WIDTH:0] NUM_CH_W = (CH_WIDTH+1)'(NUM_CH);
  localparam logic signed [DATA_WIDTH:0] ERR_MAX = (DATA_WIDTH+1)'(2**(ERR_WIDTH-1) - 1);
  localparam logic signed [DATA_WIDTH:0] ERR_MIN = (DATA_WIDTH+1)'(-(2**(ERR_WIDTH-1)));

  logic [DATA_WIDTH-1:0]        ref_bank [NUM_CH];
  logic [DATA_WIDTH-1:0]        ref_rd;
  logic                         en;
  logic                         accept;
  logic                         ch_valid;
  logic                         wr_valid;
  logic signed [DATA_WIDTH:0]   diff;
  logic                         s1_valid;
  logic signed [DATA_WIDTH:0]   s1_diff;
  logic [CH_WIDTH-1:0]          s1_ch;
  logic signed [DATA_WIDTH:0]   clamp;
  logic                         sat;
  logic                         sat_inc;

  assign en       = !m_tvalid || m_tready;
  assign s_tready = en;
  assign accept   = s_tvalid && en;
  assign ch_valid = {1'b0, s_tuser} < NUM_CH_W;
  assign wr_valid = ref_wr_en && ({1'b0, ref_wr_ch} < NUM_CH_W);
  assign sat_inc  = m_tvalid && m_tready && m_tsat;

  always_comb begin
    ref_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_tuser == CH_WIDTH'(i)) ref_rd = ref_bank[i];
    end
  end

  assign diff = $signed({1'b0, ref_rd}) - $signed({1'b0, s_tdata});

`ifdef PI_ERR_DEADBAND_EN
  logic [DATA_WIDTH:0] mag;
  assign mag = s1_diff[DATA_WIDTH] ? DATA_WIDTH'(0) - s1_diff : s1_diff;
`endif

  always_comb begin
    clamp = s1_diff;
    sat   = 1'b0;
`ifdef PI_ERR_DEADBAND_EN
    // Deadband wins over saturation: a small error is forced to zero first.
    if (mag <= {1'b0, deadband}) begin
      clamp = '0;
    end else
`endif
    if (s1_diff > ERR_MAX) begin
      clamp = ERR_MAX;
      sat   = 1'b1;
    end else if (s1_diff < ERR_MIN) begin
      clamp = ERR_MIN;
      sat   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) ref_bank[i] <= '0;
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_ch     <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tuser   <= '0;
      m_tsat    <= 1'b0;
      sat_count <= '0;
      ch_err    <= 1'b0;
    end else begin
      // Sample uses the pre-write reference since ref_rd is read combinationally here.
      if (wr_valid) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ref_wr_ch == CH_WIDTH'(i)) ref_bank[i] <= ref_wr_data;
        end
      end
      if (en) begin
        s1_valid <= accept && ch_valid;
        s1_diff  <= diff;
        s1_ch    <= s_tuser;
        m_tvalid <= s1_valid;
        m_tdata  <= clamp[ERR_WIDTH-1:0];
        m_tuser  <= s1_ch;
        m_tsat   <= s1_valid && sat;
      end
      if (stat_clr) begin
        sat_count <= '0;
        ch_err    <= 1'b0;
      end else begin
        if (sat_inc && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
        if (accept && !ch_valid) ch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pi_error_calc_mc.sv
// Bench for pi_error_calc_mc: queue-based reference model plus directed literal checks.
// Deadband vectors run only when PI_ERR_DEADBAND_EN is defined.
module tb_pi_error_calc_mc;
  localparam int DW = 16;
  localparam int EW = 16;
  localparam int NCH = 3;
  localparam int CW = 2;
  localparam int EMAX = 2**(EW-1) - 1;
  localparam int EMIN = -(2**(EW-1));

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ref_wr_en;
  logic [CW-1:0] ref_wr_ch;
  logic [DW-1:0] ref_wr_data;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [CW-1:0] s_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic [EW-1:0] m_tdata;
  logic [CW-1:0] m_tuser;
  logic          m_tsat;
  logic [15:0]   sat_count;
  logic          ch_err;
  logic          stat_clr;
`ifdef PI_ERR_DEADBAND_EN
  logic [DW-1:0] deadband;
`endif

  always #5 clk = ~clk;

  pi_error_calc_mc #(
    .DATA_WIDTH(DW), .ERR_WIDTH(EW), .NUM_CH(NCH), .CH_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ref_wr_en(ref_wr_en), .ref_wr_ch(ref_wr_ch), .ref_wr_data(ref_wr_data),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tsat(m_tsat), .sat_count(sat_count), .ch_err(ch_err), .stat_clr(stat_clr)
`ifdef PI_ERR_DEADBAND_EN
    , .deadband(deadband)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {int data; int ch; int sat;} beat_t;
  beat_t exp_q[$];
  int    mref [NCH];
  int    msat;
  int    mcherr;

  function automatic beat_t model_beat(input int r, input int s, input int ch);
    beat_t b;
    int d;
    d = r - s;
    b.sat = 0;
`ifdef PI_ERR_DEADBAND_EN
    if ((d < 0 ? -d : d) <= int'(deadband)) d = 0;
`endif
    if (d > EMAX) begin d = EMAX; b.sat = 1; end
    else if (d < EMIN) begin d = EMIN; b.sat = 1; end
    b.data = d;
    b.ch   = ch;
    return b;
  endfunction

  // Compare/model process: checks outputs, then applies the handshakes of the coming edge.
  logic  prev_hold;
  int    prev_data, prev_user, prev_sat;
  beat_t cur;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      for (int i = 0; i < NCH; i++) mref[i] = 0;
      msat = 0;
      mcherr = 0;
      prev_hold = 1'b0;
    end else begin
      chk("s_tready_rule", int'(s_tready), int'(!m_tvalid || m_tready));
      chk("sat_count", int'(sat_count), msat);
      chk("ch_err", int'(ch_err), mcherr);
      if (prev_hold) begin
        chk("hold_data", int'($signed(m_tdata)), prev_data);
        chk("hold_user", int'(m_tuser), prev_user);
        chk("hold_sat", int'(m_tsat), prev_sat);
      end
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("beat_expected", exp_q.size(), 1);
        end else begin
          chk("m_tdata", int'($signed(m_tdata)), exp_q[0].data);
          chk("m_tuser", int'(m_tuser), exp_q[0].ch);
          chk("m_tsat", int'(m_tsat), exp_q[0].sat);
        end
      end
      if (m_tvalid && m_tready && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (cur.sat != 0 && msat < 65535) msat++;
      end
      if (s_tvalid && s_tready) begin
        if (int'(s_tuser) < NCH) exp_q.push_back(model_beat(mref[s_tuser], int'(s_tdata),
                                                            int'(s_tuser)));
        else mcherr = 1;
      end
      if (stat_clr) begin
        msat = 0;
        mcherr = 0;
      end
      if (ref_wr_en && int'(ref_wr_ch) < NCH) mref[ref_wr_ch] = int'(ref_wr_data);
      prev_hold = m_tvalid && !m_tready;
      prev_data = int'($signed(m_tdata));
      prev_user = int'(m_tuser);
      prev_sat  = int'(m_tsat);
    end
  end

  int got[$];
  logic cap_en = 1'b0;
  always @(negedge clk) begin
    if (cap_en && reset_n && m_tvalid && m_tready) got.push_back(int'($signed(m_tdata)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_ref(input int ch, input int val);
    ref_wr_en = 1'b1; ref_wr_ch = CW'(ch); ref_wr_data = DW'(val);
    step();
    ref_wr_en = 1'b0;
  endtask

  task automatic send(input int ch, input int val);
    s_tvalid = 1'b1; s_tuser = CW'(ch); s_tdata = DW'(val);
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int exp_data, input int exp_sat);
    int n = 0;
    while (!m_tvalid && n < 10) begin step(); n++; end
    chk({name, "_valid"}, int'(m_tvalid), 1);
    chk(name, int'($signed(m_tdata)), exp_data);
    chk({name, "_sat"}, int'(m_tsat), exp_sat);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int idx, stall, n;
    logic first, acc;
    reset_n = 1'b0; ref_wr_en = 1'b0; ref_wr_ch = '0; ref_wr_data = '0;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; m_tready = 1'b1; stat_clr = 1'b0;
`ifdef PI_ERR_DEADBAND_EN
    deadband = '0;
`endif
    repeat (3) step();
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_m_tdata", int'(m_tdata), 0);
    chk("rst_m_tuser", int'(m_tuser), 0);
    chk("rst_m_tsat", int'(m_tsat), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_ch_err", int'(ch_err), 0);
    reset_n = 1'b1;
    chk("rst_s_tready", int'(s_tready), 1);

    // Basic error and two-cycle latency.
    wr_ref(0, 1000);
    send(0, 400);
    chk("lat_n1_valid", int'(m_tvalid), 0);
    step();
    chk("lat_n2_valid", int'(m_tvalid), 1);
    chk("lat_n2_data", int'($signed(m_tdata)), 600);
    chk("lat_n2_user", int'(m_tuser), 0);
    chk("lat_n2_sat", int'(m_tsat), 0);
    step();

    // Saturation at both rails.
    send(1, 16'hFFFF);
    wait_out("sat_neg", -32768, 1);
    chk("sat_cnt1", int'(sat_count), 1);
    wr_ref(1, 16'hFFFF);
    send(1, 0);
    wait_out("sat_pos", 32767, 1);
    chk("sat_cnt2", int'(sat_count), 2);

    // Stream with a three-cycle downstream stall after the first output.
    wr_ref(2, 50);
    cap_en = 1'b1;
    idx = 0; stall = 0; first = 1'b0;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      if (m_tvalid && !first) begin first = 1'b1; m_tready = 1'b1; end
      else if (first && stall < 3) begin m_tready = 1'b0; stall++; end
      else m_tready = 1'b1;
      s_tvalid = idx < 5; s_tdata = DW'(10 * (idx + 1)); s_tuser = 2'd2;
      #1;
      acc = s_tvalid && s_tready;
      if (!m_tready) chk("stall_s_tready", int'(s_tready), 0);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    s_tvalid = 1'b0; m_tready = 1'b1; cap_en = 1'b0;
    chk("stream_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("stream_order", got[i], 40 - 10 * i);
    chk("stream_stalls", stall, 3);

    // Reference write colliding with a sample on the same channel.
    wr_ref(1, 100);
    ref_wr_en = 1'b1; ref_wr_ch = 2'd1; ref_wr_data = 16'd200;
    s_tvalid = 1'b1; s_tuser = 2'd1; s_tdata = 16'd60;
    step();
    ref_wr_en = 1'b0;
    step();
    s_tvalid = 1'b0;
    wait_out("coll_old", 40, 0);
    wait_out("coll_new", 140, 0);

    // Invalid channel and statistics clear.
    send(3, 123);
    repeat (4) begin chk("inv_no_valid", int'(m_tvalid), 0); step(); end
    chk("inv_ch_err", int'(ch_err), 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_ch_err", int'(ch_err), 0);
    chk("clr_sat_count", int'(sat_count), 0);

    // Clear coinciding with a saturated handshake leaves zero.
    wr_ref(1, 16'hFFFF);
    send(1, 0);
    n = 0;
    while (!m_tvalid && n < 10) begin step(); n++; end
    chk("clr_coinc_tsat", int'(m_tsat), 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_coinc_count", int'(sat_count), 0);

    // Reset mid-flight drops the sample and clears references.
    send(0, 400);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("midrst_s_tready", int'(s_tready), 1);
    repeat (3) begin chk("midrst_no_valid", int'(m_tvalid), 0); step(); end
    send(0, 400);
    wait_out("ref_after_rst", -400, 0);

`ifdef PI_ERR_DEADBAND_EN
    deadband = 16'd10;
    wr_ref(0, 100);
    send(0, 95);
    wait_out("db_95", 0, 0);
    send(0, 85);
    wait_out("db_85", 15, 0);
    send(0, 110);
    wait_out("db_110", 0, 0);
    send(0, 111);
    wait_out("db_111", -11, 0);
`endif

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi_error_calc_mc.md
# pi_error_calc_mc

Multi-channel, pipelined error stage for the PI controller chain: computes per-channel `error = reference - sample` and saturates the signed result to the output width. It sits between the ADC sample stream and the PI core. It holds one programmable reference per channel and uses AXI-Stream-style valid/ready on both sides. It also provides saturation statistics and invalid-channel detection.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of unsigned reference and sample codes.
- `ERR_WIDTH`, 16: width of signed error output; must be `<= DATA_WIDTH+1`.
- `NUM_CH`, 3: number of channels; must be `<= 2**CH_WIDTH`.
- `CH_WIDTH`, 2: width of channel index fields.

Ports (reset `reset_n`, synchronous, active-low; clock `clk`):
- `clk`, in, 1: clock.
- `reset_n`, in, 1: synchronous active-low reset.
- `ref_wr_en`, in, 1: reference write strobe.
- `ref_wr_ch`, in, CH_WIDTH: reference channel to write.
- `ref_wr_data`, in, DATA_WIDTH: unsigned reference value.
- `s_tvalid`, in, 1: sample valid.
- `s_tready`, out, 1: sample accepted when high with `s_tvalid`.
- `s_tdata`, in, DATA_WIDTH: unsigned sample.
- `s_tuser`, in, CH_WIDTH: sample channel index.
- `m_tvalid`, out, 1: error valid.
- `m_tready`, in, 1: downstream ready.
- `m_tdata`, out, ERR_WIDTH: signed saturated error.
- `m_tuser`, out, CH_WIDTH: channel index of the error.
- `m_tsat`, out, 1: this error was saturated.
- `sat_count`, out, 16: saturating count of saturated outputs.
- `ch_err`, out, 1: sticky flag, set when an invalid channel sample is received.
- `stat_clr`, in, 1: clears `sat_count` and `ch_err`.
- `deadband`, in, DATA_WIDTH: unsigned deadband magnitude. Present only with `PI_ERR_DEADBAND_EN`.

## Operation
- Reference bank: `NUM_CH` registers, all 0 at reset.
  - `ref_wr_en` writes `ref_wr_data` to `ref[ref_wr_ch]`.
  - Writes with `ref_wr_ch >= NUM_CH` are ignored.
- Stage 1, on accept (`s_tvalid & s_tready`):
  - `diff = {1'b0,ref[s_tuser]} - {1'b0,s_tdata}`, signed, DATA_WIDTH+1 bits.
  - The channel index is registered alongside `diff`.
- Stage 2: `diff` is clamped to `[-2**(ERR_WIDTH-1), 2**(ERR_WIDTH-1)-1]`.
  - `m_tsat` = 1 iff clamping changed the value.
  - The clamped value drives `m_tdata`.
- Global stall enable: `en = !m_tvalid | m_tready`.
  - `s_tready = en`.
  - Both stages advance only when `en` is high.
  - Bubbles are not collapsed while stalled.
- Output ordering equals input order; no sample is lost or duplicated under backpressure.
- Invalid channel (`s_tuser >= NUM_CH`):
  - The sample is accepted (consumed) but produces no output beat.
  - `ch_err` is set.
- `sat_count` increments by 1 on each output handshake (`m_tvalid & m_tready`) with `m_tsat=1`. It holds at 0xFFFF.
- `stat_clr` clears `sat_count` and `ch_err`. If `stat_clr` coincides with an increment or set event in the same cycle, the result is 0.

## Timing
- Reset values: all refs 0, pipeline valids 0, `m_tvalid` 0, `m_tdata` 0, `m_tuser` 0, `m_tsat` 0, `sat_count` 0, `ch_err` 0.
- Reset mid-operation discards all in-flight samples; the first cycle after reset deasserts has `s_tready=1`.
- Latency: a sample accepted in cycle N appears on `m_tvalid` in cycle N+2 when there is no stall.
- Throughput: 1 sample/cycle when `m_tready` is held high.
- `m_tdata`, `m_tuser`, and `m_tsat` are stable while `m_tvalid & !m_tready`.
- Reference read/write collision: a sample accepted in the same cycle as a write to its channel uses the old reference. The next accepted sample uses the new one.

## Configuration
- `PI_ERR_DEADBAND_EN` defined:
  - The `deadband` port exists.
  - In stage 2, if `|diff| <= deadband`, the output is 0 and `m_tsat` is 0.
  - The deadband check precedes saturation.
- Undefined: no `deadband` port; the error passes straight to saturation. Latency is identical in both builds.

## Test plan
Defaults (16/16/3/2) unless stated.
- Write ref ch0=1000; send sample 400 ch0, `m_tready=1` -> two cycles later `m_tdata=600`, `m_tuser=0`, `m_tsat=0`.
- ref ch1=0, sample 0xFFFF ch1 -> `m_tdata=-32768`, `m_tsat=1`, `sat_count=1`. Then ref ch1=0xFFFF, sample 0 -> `m_tdata=32767`, `m_tsat=1`, `sat_count=2`.
- Stream 5 samples on ch2 (ref 50, samples 10,20,30,40,50). Hold `m_tready=0` for 3 cycles after the first output -> `s_tready` low during the stall; outputs are 40,30,20,10,0 in order with none lost.
- ref ch1=100. In the same cycle, write ch1=200 and accept sample 60 ch1 -> output 40. The next sample 60 ch1 -> output 140.
- Sample on ch3 (invalid) -> no `m_tvalid`, `ch_err=1`. Assert `stat_clr` -> `ch_err=0`, `sat_count=0`.
- With `PI_ERR_DEADBAND_EN`, deadband=10:
  - ref 100, sample 95 -> output 0.
  - sample 85 -> output 15.
  - sample 110 -> 0.
  - sample 111 -> -11.
